// File: rtl/gpio_bank_arbiter.sv
// Round-robin owner arbitration for one shared tristate GPIO bank, with a forced
// all-tristate turnaround between owners and an optional hold limit.
module gpio_bank_arbiter #(
    parameter int PINS       = 4,
    parameter int REQUESTERS = 2,
    parameter int TURNAROUND = 2,
    parameter int MAX_HOLD   = 0
) (
    input  logic                         io_sys_clock,
    input  logic                         io_sys_reset,
    input  logic [REQUESTERS-1:0]        io_req,
    output logic [REQUESTERS-1:0]        io_grant,
    input  logic [REQUESTERS*PINS-1:0]   io_req_write,
    input  logic [REQUESTERS*PINS-1:0]   io_req_writeEnable,
    output logic [PINS-1:0]              io_req_read,
    output logic [1:0]                   io_owner,
    output logic                         io_busy,
    input  logic [PINS-1:0]              io_pins_read,
    output logic [PINS-1:0]              io_pins_write,
    output logic [PINS-1:0]              io_pins_writeEnable
);

    localparam logic [3:0]            TURN_LOAD  = 4'(TURNAROUND);
    localparam logic [15:0]           HOLD_LIMIT = 16'(MAX_HOLD);
    localparam logic [15:0]           HOLD_LAST  = (MAX_HOLD == 0) ? 16'd0 : 16'(MAX_HOLD - 1);
    localparam logic [1:0]            LAST_INIT  = 2'(REQUESTERS - 1);
    localparam logic [REQUESTERS-1:0] HOT_ZERO   = REQUESTERS'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TURN = 2'd1,
        OWN  = 2'd2
    } state_t;

    state_t                state_r;
    logic [1:0]            owner_r;
    logic [1:0]            lastOwner_r;
    logic [3:0]            turnCnt_r;
    logic [15:0]           holdCnt_r;
    logic [REQUESTERS-1:0] grant_r;
    logic [PINS-1:0]       pinsWrite_r;
    logic [PINS-1:0]       pinsWe_r;
    logic                  busy_r;
    logic [PINS-1:0]       readMeta_r;
    logic [PINS-1:0]       readSync_r;

    logic [REQUESTERS-1:0] ownerHot_s;
    logic [PINS-1:0]       ownerWrite_s;
    logic [PINS-1:0]       ownerWe_s;
    logic                  ownerReq_s;
    logic                  othersReq_s;
    logic                  anyReq_s;
    logic                  forceRelease_s;
    logic [1:0]            winner_s;

    // First requester scanning upward from last+1 with wrap; smallest offset wins.
    function automatic logic [1:0] pickWinner(input logic [REQUESTERS-1:0] req,
                                              input logic [1:0] last);
        logic [1:0] pick;
        int         slot;
        pick = last;
        for (int k = REQUESTERS; k >= 1; k--) begin
            slot = (int'(last) + k) % REQUESTERS;
            for (int i = 0; i < REQUESTERS; i++) begin
                pick = ((i == slot) && req[i]) ? 2'(i) : pick;
            end
        end
        return pick;
    endfunction

    // Select the owner's request and pin slice; other slices are masked off.
    always_comb begin
        ownerHot_s   = HOT_ZERO << owner_r;
        ownerWrite_s = '0;
        ownerWe_s    = '0;
        for (int i = 0; i < REQUESTERS; i++) begin
            ownerWrite_s = ownerWrite_s | (io_req_write[i*PINS +: PINS] & {PINS{ownerHot_s[i]}});
            ownerWe_s    = ownerWe_s | (io_req_writeEnable[i*PINS +: PINS] & {PINS{ownerHot_s[i]}});
        end
    end

    assign ownerReq_s     = |(io_req & ownerHot_s);
    assign othersReq_s    = |(io_req & ~ownerHot_s);
    assign anyReq_s       = |io_req;
    assign winner_s       = pickWinner(io_req, lastOwner_r);
    // Holding counts completed OWN cycles, so the limit cycle is HOLD_LAST.
    assign forceRelease_s = (HOLD_LIMIT != 16'd0) && othersReq_s && (holdCnt_r >= HOLD_LAST);

    // Arbitration FSM, registered pin drive and the read-back synchronizer.
    always_ff @(posedge io_sys_clock or negedge io_sys_reset) begin
        if (!io_sys_reset) begin
            state_r     <= IDLE;
            owner_r     <= 2'd0;
            lastOwner_r <= LAST_INIT;
            turnCnt_r   <= 4'd0;
            holdCnt_r   <= 16'd0;
            grant_r     <= '0;
            pinsWrite_r <= '0;
            pinsWe_r    <= '0;
            busy_r      <= 1'b0;
            readMeta_r  <= '0;
            readSync_r  <= '0;
        end else begin
            readMeta_r <= io_pins_read;
            readSync_r <= readMeta_r;
            case (state_r)
                IDLE: begin
                    grant_r     <= '0;
                    pinsWrite_r <= '0;
                    pinsWe_r    <= '0;
                    if (anyReq_s) begin
                        owner_r   <= winner_s;
                        turnCnt_r <= TURN_LOAD;
                        busy_r    <= 1'b1;
                        state_r   <= TURN;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                TURN: begin
                    pinsWrite_r <= '0;
                    pinsWe_r    <= '0;
                    if (!ownerReq_s) begin
                        grant_r <= '0;
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end else if (turnCnt_r <= 4'd1) begin
                        grant_r   <= ownerHot_s;
                        holdCnt_r <= 16'd0;
                        state_r   <= OWN;
                    end else begin
                        turnCnt_r <= turnCnt_r - 4'd1;
                    end
                end
                OWN: begin
                    if (!ownerReq_s || forceRelease_s) begin
                        grant_r     <= '0;
                        pinsWrite_r <= '0;
                        pinsWe_r    <= '0;
                        busy_r      <= 1'b0;
                        lastOwner_r <= owner_r;
                        state_r     <= IDLE;
                    end else begin
                        pinsWrite_r <= ownerWrite_s;
                        pinsWe_r    <= ownerWe_s;
                        holdCnt_r   <= (holdCnt_r >= HOLD_LIMIT) ? holdCnt_r : holdCnt_r + 16'd1;
                    end
                end
                default: begin
                    grant_r     <= '0;
                    pinsWrite_r <= '0;
                    pinsWe_r    <= '0;
                    busy_r      <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign io_grant            = grant_r;
    assign io_owner            = owner_r;
    assign io_busy             = busy_r;
    assign io_pins_write       = pinsWrite_r;
    assign io_pins_writeEnable = pinsWe_r;
    assign io_req_read         = readSync_r;

endmodule

// File: tb/tb_gpio_bank_arbiter.sv
// Scoreboard bench for gpio_bank_arbiter: expectations are queued per cycle when
// stimulus is driven and compared on the falling edge of that cycle.
module tb_gpio_bank_arbiter;

    localparam int PINS = 4;
    localparam int REQ  = 2;
    localparam int TA   = 2;
    localparam int MH   = 8;

    localparam int SEL_GRANT = 0;
    localparam int SEL_PW    = 1;
    localparam int SEL_PWE   = 2;
    localparam int SEL_BUSY  = 3;
    localparam int SEL_OWNER = 4;
    localparam int SEL_RD    = 5;

    logic                 clk = 1'b0;
    logic                 rstN;
    logic [REQ-1:0]       req;
    logic [REQ-1:0]       grant;
    logic [REQ*PINS-1:0]  reqWrite;
    logic [REQ*PINS-1:0]  reqWe;
    logic [PINS-1:0]      reqRead;
    logic [1:0]           owner;
    logic                 busy;
    logic [PINS-1:0]      pinsRead;
    logic [PINS-1:0]      pinsWrite;
    logic [PINS-1:0]      pinsWe;

    gpio_bank_arbiter #(
        .PINS(PINS), .REQUESTERS(REQ), .TURNAROUND(TA), .MAX_HOLD(MH)
    ) dut (
        .io_sys_clock        (clk),
        .io_sys_reset        (rstN),
        .io_req              (req),
        .io_grant            (grant),
        .io_req_write        (reqWrite),
        .io_req_writeEnable  (reqWe),
        .io_req_read         (reqRead),
        .io_owner            (owner),
        .io_busy             (busy),
        .io_pins_read        (pinsRead),
        .io_pins_write       (pinsWrite),
        .io_pins_writeEnable (pinsWe)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int         cyc;
        int         sel;
        logic [7:0] exp;
        string      tag;
    } sbEntry_t;

    sbEntry_t sb[$];
    sbEntry_t monEntry;

    task automatic checkEq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] sample(input int sel);
        case (sel)
            SEL_GRANT: return {6'd0, grant};
            SEL_PW:    return {4'd0, pinsWrite};
            SEL_PWE:   return {4'd0, pinsWe};
            SEL_BUSY:  return {7'd0, busy};
            SEL_OWNER: return {6'd0, owner};
            SEL_RD:    return {4'd0, reqRead};
            default:   return 8'hFF;
        endcase
    endfunction

    // Insert keeping the queue ordered by cycle.
    task automatic expectAt(input int c, input int sel, input logic [7:0] v, input string tag);
        sbEntry_t e;
        int pos;
        e.cyc = c; e.sel = sel; e.exp = v; e.tag = tag;
        pos = sb.size();
        for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].cyc > c && pos == sb.size()) pos = i;
        end
        sb.insert(pos, e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        while (sb.size() != 0 && sb[0].cyc <= cyc) begin
            monEntry = sb.pop_front();
            checkEq($sformatf("%s@%0d", monEntry.tag, monEntry.cyc),
                    16'(sample(monEntry.sel)), 16'(monEntry.exp));
        end
    end

    initial begin
        int b;
        int g;
        int c;
        int o;
        logic [7:0] hot;
        logic [7:0] otherHot;
        logic [7:0] slice;

        rstN     = 1'b0;
        req      = '0;
        reqWrite = {4'h5, 4'hA};
        reqWe    = {4'h3, 4'hF};
        pinsRead = 4'hF;
        #12;
        checkEq("rst_grant", 16'(grant), 16'h0);
        checkEq("rst_pw", 16'(pinsWrite), 16'h0);
        checkEq("rst_pwe", 16'(pinsWe), 16'h0);
        checkEq("rst_busy", 16'(busy), 16'h0);
        checkEq("rst_owner", 16'(owner), 16'h0);
        checkEq("rst_rd", 16'(reqRead), 16'h0);
        pinsRead = 4'h0;
        #10 rstN = 1'b1;
        step(1);

        // Single requester: first grant and first drive latency.
        b = cyc;
        req = 2'b01;
        for (int d = 0; d < 4; d++) expectAt(b + d, SEL_PWE, 8'h0, "s1_pwe_early");
        expectAt(b,     SEL_BUSY,  8'h0, "s1_busy");
        expectAt(b + 1, SEL_BUSY,  8'h1, "s1_busy");
        expectAt(b + 1, SEL_OWNER, 8'h0, "s1_owner");
        expectAt(b + 2, SEL_GRANT, 8'h0, "s1_grant");
        expectAt(b + 3, SEL_GRANT, 8'h1, "s1_grant");
        expectAt(b + 4, SEL_PW,    8'hA, "s1_pw");
        expectAt(b + 4, SEL_PWE,   8'hF, "s1_pwe");
        step(6);
        req = 2'b00;
        expectAt(b + 7, SEL_GRANT, 8'h0, "s1_rel_grant");
        expectAt(b + 7, SEL_PWE,   8'h0, "s1_rel_pwe");
        expectAt(b + 7, SEL_BUSY,  8'h0, "s1_rel_busy");
        step(3);

        // Round robin: both held, each drops for one cycle after five OWN cycles.
        reqWrite = {4'hC, 4'h3};
        reqWe    = 8'hFF;
        g = cyc + 3;
        req = 2'b11;
        for (int j = 0; j < 4; j++) begin
            o        = (j % 2 == 0) ? 1 : 0;
            hot      = (o == 1) ? 8'h2 : 8'h1;
            otherHot = (o == 1) ? 8'h1 : 8'h2;
            slice    = (o == 1) ? 8'hC : 8'h3;
            expectAt(g,     SEL_GRANT, hot, "rr_grant");
            expectAt(g + 1, SEL_PW,    slice, "rr_pw");
            expectAt(g + 1, SEL_PWE,   8'hF, "rr_pwe");
            expectAt(g + 4, SEL_GRANT, hot, "rr_grant_hold");
            expectAt(g + 5, SEL_GRANT, 8'h0, "rr_grant_rel");
            for (int d = 1; d <= 4; d++) expectAt(g + 4 + d, SEL_PWE, 8'h0, "rr_gap_pwe");
            expectAt(g + 8, SEL_GRANT, otherHot, "rr_next_grant");
            step(g + 4 - cyc);
            req[o] = 1'b0;
            step(1);
            req[o] = 1'b1;
            step(3);
            g = g + 8;
        end
        req = 2'b00;
        expectAt(g + 1, SEL_GRANT, 8'h0, "rr_end_grant");
        expectAt(g + 1, SEL_BUSY,  8'h0, "rr_end_busy");
        step(3);

        // Forced release after MAX_HOLD OWN cycles while requester 1 waits.
        req = 2'b01;
        g = cyc + 3;
        expectAt(g,      SEL_GRANT, 8'h1, "fr_grant0");
        expectAt(g + 7,  SEL_GRANT, 8'h1, "fr_grant0_last");
        expectAt(g + 8,  SEL_GRANT, 8'h0, "fr_drop");
        for (int d = 8; d <= 11; d++) expectAt(g + d, SEL_PWE, 8'h0, "fr_gap_pwe");
        expectAt(g + 9,  SEL_OWNER, 8'h1, "fr_owner1");
        expectAt(g + 10, SEL_GRANT, 8'h0, "fr_turn");
        expectAt(g + 11, SEL_GRANT, 8'h2, "fr_grant1");
        expectAt(g + 16, SEL_GRANT, 8'h1, "fr_regrant0");
        expectAt(g + 18, SEL_GRANT, 8'h0, "fr_end");
        step(4);
        req[1] = 1'b1;
        step(11);
        req[1] = 1'b0;
        step(5);
        req[0] = 1'b0;
        step(3);

        // Withdrawal during TURN leaves last owner alone.
        b = cyc;
        req = 2'b10;
        expectAt(b + 1, SEL_BUSY,  8'h1, "wd_busy");
        expectAt(b + 1, SEL_OWNER, 8'h1, "wd_owner");
        expectAt(b + 2, SEL_BUSY,  8'h0, "wd_idle");
        for (int d = 1; d <= 4; d++) expectAt(b + d, SEL_GRANT, 8'h0, "wd_no_grant");
        step(1);
        req[1] = 1'b0;
        step(3);
        req = 2'b11;
        expectAt(b + 5, SEL_OWNER, 8'h1, "wd_pref1");
        expectAt(b + 6, SEL_GRANT, 8'h0, "wd_turn");
        expectAt(b + 7, SEL_GRANT, 8'h2, "wd_grant1");
        step(4);
        req = 2'b00;
        expectAt(b + 9, SEL_GRANT, 8'h0, "wd_end");
        step(3);

        // Asynchronous reset while driving.
        req = 2'b01;
        g = cyc + 3;
        expectAt(g,     SEL_GRANT, 8'h1, "ar_grant");
        expectAt(g + 1, SEL_PWE,   8'hF, "ar_pwe");
        step(5);
        checkEq("ar_pwe_pre", 16'(pinsWe), 16'hF);
        #2 rstN = 1'b0;
        #1;
        checkEq("ar_pwe_rst", 16'(pinsWe), 16'h0);
        checkEq("ar_grant_rst", 16'(grant), 16'h0);
        checkEq("ar_busy_rst", 16'(busy), 16'h0);
        #2 rstN = 1'b1;
        c = cyc;
        expectAt(c + 1, SEL_BUSY,  8'h1, "ar_turn_busy");
        expectAt(c + 1, SEL_GRANT, 8'h0, "ar_turn_grant");
        for (int d = 1; d <= 3; d++) expectAt(c + d, SEL_PWE, 8'h0, "ar_turn_pwe");
        expectAt(c + 3, SEL_GRANT, 8'h1, "ar_regrant");
        expectAt(c + 4, SEL_PWE,   8'hF, "ar_redrive");
        step(4);
        req = 2'b00;
        expectAt(c + 5, SEL_GRANT, 8'h0, "ar_end");
        step(3);

        // Read synchronizer latency in IDLE, TURN and OWN.
        b = cyc;
        pinsRead = 4'h5;
        expectAt(b + 1, SEL_RD,   8'h0, "rd_idle_early");
        expectAt(b + 2, SEL_RD,   8'h5, "rd_idle");
        expectAt(b + 2, SEL_BUSY, 8'h0, "rd_idle_state");
        step(3);
        pinsRead = 4'h0;
        step(3);
        c = cyc;
        req = 2'b01;
        pinsRead = 4'h5;
        expectAt(c + 1, SEL_RD,    8'h0, "rd_turn_early");
        expectAt(c + 2, SEL_RD,    8'h5, "rd_turn");
        expectAt(c + 2, SEL_BUSY,  8'h1, "rd_turn_busy");
        expectAt(c + 2, SEL_GRANT, 8'h0, "rd_turn_grant");
        step(3);
        pinsRead = 4'h0;
        step(3);
        pinsRead = 4'h5;
        expectAt(c + 7, SEL_RD,    8'h0, "rd_own_early");
        expectAt(c + 8, SEL_RD,    8'h5, "rd_own");
        expectAt(c + 8, SEL_GRANT, 8'h1, "rd_own_grant");
        step(3);
        req = 2'b00;
        step(3);

        checkEq("sb_drain", 16'(sb.size()), 16'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
